// File: rtl/clock_pkg.sv
// Shared types and limits for the BCD time-of-day counter.
// The alarm states exist in mode_t always; they are only reachable with CLOCK_TIME_COUNTER_ALARM_EN.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    MODE_RUN        = 3'd0,
    MODE_SET_HR     = 3'd1,
    MODE_SET_MIN    = 3'd2,
    MODE_SET_AL_HR  = 3'd3,
    MODE_SET_AL_MIN = 3'd4
  } mode_t;

  localparam bcd_t DIGIT_MAX      = 4'd9;
  localparam bcd_t SEC_HI_MAX     = 4'd5;
  localparam bcd_t MIN_HI_MAX     = 4'd5;
  localparam bcd_t HR_MAX_HI      = 4'd2;
  localparam bcd_t HR_MAX_LO_AT_2 = 4'd3;

  localparam logic [1:0] EDIT_RUN = 2'b00;
  localparam logic [1:0] EDIT_HR  = 2'b01;
  localparam logic [1:0] EDIT_MIN = 2'b10;
  localparam logic [1:0] EDIT_AL  = 2'b11;

  function automatic logic [1:0] edit_sel_of(input mode_t m);
    case (m)
      MODE_SET_HR:                     return EDIT_HR;
      MODE_SET_MIN:                    return EDIT_MIN;
      MODE_SET_AL_HR, MODE_SET_AL_MIN: return EDIT_AL;
      default:                         return EDIT_RUN;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counting 0..MAX with synchronous clear (priority over inc).
// carry_o is combinational so a whole HH:MM:SS ripple settles in one cycle.
module bcd_digit_cnt
  import clock_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output bcd_t value_o,
  output logic carry_o
);

  bcd_t value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i) begin
      value_d = (value_q == MAX) ? '0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign carry_o = inc_i && (value_q == MAX);

endmodule

// File: rtl/clock_time_counter.sv
// 24-hour HH:MM:SS BCD clock with a 1 Hz prescaler and a button-driven set mode.
// Define CLOCK_TIME_COUNTER_ALARM_EN to add an HH:MM alarm with its own edit states.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
  input  logic       alarm_on,
  output logic       alarm_o,
`endif
  output bcd_t       h_hi,
  output bcd_t       h_lo,
  output bcd_t       m_hi,
  output bcd_t       m_lo,
  output bcd_t       s_hi,
  output bcd_t       s_lo,
  output logic       sec_tick,
  output logic [1:0] edit_sel,
  output mode_t      dbg_state_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  mode_t         state_q;
  logic [1:0]    edit_sel_q;
  logic [PW-1:0] pre_q, pre_d;
  logic          sec_tick_q;

  logic in_run, tick_en, inc_act, back_to_run;
  logic hr_inc, hr_wrap;
  logic s_lo_cy, s_hi_cy, m_lo_cy, m_hi_cy, h_lo_cy, h_hi_cy;

  // mode_btn wins over a simultaneous inc_btn.
  assign inc_act = inc_btn && !mode_btn;
  assign in_run  = (state_q == MODE_RUN);
  assign tick_en = in_run && (pre_q == PRE_MAX);
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
  assign back_to_run = mode_btn && (state_q == MODE_SET_AL_MIN);
`else
  assign back_to_run = mode_btn && (state_q == MODE_SET_MIN);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MODE_RUN;
      edit_sel_q <= EDIT_RUN;
    end else begin
      case (state_q)
        MODE_RUN: if (mode_btn) begin
          state_q    <= MODE_SET_HR;
          edit_sel_q <= edit_sel_of(MODE_SET_HR);
        end
        MODE_SET_HR: if (mode_btn) begin
          state_q    <= MODE_SET_MIN;
          edit_sel_q <= edit_sel_of(MODE_SET_MIN);
        end
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
        MODE_SET_MIN: if (mode_btn) begin
          state_q    <= MODE_SET_AL_HR;
          edit_sel_q <= edit_sel_of(MODE_SET_AL_HR);
        end
        MODE_SET_AL_HR: if (mode_btn) begin
          state_q    <= MODE_SET_AL_MIN;
          edit_sel_q <= edit_sel_of(MODE_SET_AL_MIN);
        end
        MODE_SET_AL_MIN: if (mode_btn) begin
          state_q    <= MODE_RUN;
          edit_sel_q <= edit_sel_of(MODE_RUN);
        end
`else
        MODE_SET_MIN: if (mode_btn) begin
          state_q    <= MODE_RUN;
          edit_sel_q <= edit_sel_of(MODE_RUN);
        end
`endif
        default: begin
          state_q    <= MODE_RUN;
          edit_sel_q <= EDIT_RUN;
        end
      endcase
    end
  end

  // Prescaler only runs in RUN; it is parked at 0 while editing so the
  // first tick after returning to RUN is a full TICK_DIV cycles away.
  always_comb begin
    pre_d = pre_q + 1'b1;
    if (!in_run || mode_btn || tick_en) pre_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      sec_tick_q <= tick_en;
    end
  end

  bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_s_lo (.clk(clk), .rst_n(rst_n), .inc_i(tick_en),
    .clr_i(back_to_run), .value_o(s_lo), .carry_o(s_lo_cy));
  bcd_digit_cnt #(.MAX(SEC_HI_MAX)) u_s_hi (.clk(clk), .rst_n(rst_n), .inc_i(s_lo_cy),
    .clr_i(back_to_run), .value_o(s_hi), .carry_o(s_hi_cy));
  bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_m_lo (.clk(clk), .rst_n(rst_n),
    .inc_i(s_hi_cy || (inc_act && state_q == MODE_SET_MIN)),
    .clr_i(1'b0), .value_o(m_lo), .carry_o(m_lo_cy));
  bcd_digit_cnt #(.MAX(MIN_HI_MAX)) u_m_hi (.clk(clk), .rst_n(rst_n), .inc_i(m_lo_cy),
    .clr_i(1'b0), .value_o(m_hi), .carry_o(m_hi_cy));

  // Minute carry reaches the hours only from a real tick, never from editing.
  assign hr_inc  = (tick_en && m_hi_cy) || (inc_act && state_q == MODE_SET_HR);
  assign hr_wrap = hr_inc && (h_hi == HR_MAX_HI) && (h_lo == HR_MAX_LO_AT_2);

  bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_h_lo (.clk(clk), .rst_n(rst_n), .inc_i(hr_inc && !hr_wrap),
    .clr_i(hr_wrap), .value_o(h_lo), .carry_o(h_lo_cy));
  bcd_digit_cnt #(.MAX(HR_MAX_HI)) u_h_hi (.clk(clk), .rst_n(rst_n), .inc_i(h_lo_cy),
    .clr_i(hr_wrap), .value_o(h_hi), .carry_o(h_hi_cy));

`ifdef CLOCK_TIME_COUNTER_ALARM_EN
  bcd_t al_h_hi, al_h_lo, al_m_hi, al_m_lo;
  logic al_h_lo_cy, al_h_hi_cy, al_m_lo_cy, al_m_hi_cy;
  logic al_hr_inc, al_wrap, alarm_q;

  assign al_hr_inc = inc_act && (state_q == MODE_SET_AL_HR);
  assign al_wrap   = al_hr_inc && (al_h_hi == HR_MAX_HI) && (al_h_lo == HR_MAX_LO_AT_2);

  bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_al_h_lo (.clk(clk), .rst_n(rst_n),
    .inc_i(al_hr_inc && !al_wrap), .clr_i(al_wrap), .value_o(al_h_lo), .carry_o(al_h_lo_cy));
  bcd_digit_cnt #(.MAX(HR_MAX_HI)) u_al_h_hi (.clk(clk), .rst_n(rst_n),
    .inc_i(al_h_lo_cy), .clr_i(al_wrap), .value_o(al_h_hi), .carry_o(al_h_hi_cy));
  bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_al_m_lo (.clk(clk), .rst_n(rst_n),
    .inc_i(inc_act && state_q == MODE_SET_AL_MIN), .clr_i(1'b0),
    .value_o(al_m_lo), .carry_o(al_m_lo_cy));
  bcd_digit_cnt #(.MAX(MIN_HI_MAX)) u_al_m_hi (.clk(clk), .rst_n(rst_n),
    .inc_i(al_m_lo_cy), .clr_i(1'b0), .value_o(al_m_hi), .carry_o(al_m_hi_cy));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= in_run && alarm_on &&
                 ({h_hi, h_lo, m_hi, m_lo} == {al_h_hi, al_h_lo, al_m_hi, al_m_lo});
    end
  end

  assign alarm_o = alarm_q;

  logic unused_carry;
  assign unused_carry = h_hi_cy ^ al_h_hi_cy ^ al_m_hi_cy;
`else
  logic unused_carry;
  assign unused_carry = h_hi_cy;
`endif

  assign sec_tick    = sec_tick_q;
  assign edit_sel    = edit_sel_q;
  assign dbg_state_o = state_q;

endmodule
